pipe_reg: RTL

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_reg.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - two-entry skid pipeline register with flush and bubble control zeroing.
// Optional stall counter output stall_cnt_o enabled by macro PIPE_REG_STALL_CNT_EN.
module pipe_reg #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic [DATA_W-1:0] dn_data_o
`ifdef PIPE_REG_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   main_data_q;
    logic [CTRL_W-1:0]   main_ctrl_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic [CTRL_W-1:0]   skid_ctrl_q;
    logic                load_main;
    logic                load_skid;
    logic                skid_to_main;
    logic                up_fire;
    logic                dn_fire;

    // Ready depends only on registered state so dn_ready_i never reaches upstream.
    assign up_ready_o = (state_q != FULL);
    assign dn_valid_o = (state_q == ONE) || (state_q == FULL);
    assign dn_data_o  = main_data_q;
    assign dn_ctrl_o  = dn_valid_o ? main_ctrl_q : '0;

    assign up_fire = up_valid_i & up_ready_o;
    assign dn_fire = dn_valid_o & dn_ready_i;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            EMPTY: begin
                if (up_fire) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                case ({up_fire, dn_fire})
                    2'b11: load_main = 1'b1;
                    2'b10: begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    default: state_d = ONE;
                endcase
            end
            FULL: begin
                if (dn_fire) begin
                    skid_to_main = 1'b1;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush_i) begin
            state_d      = EMPTY;
            load_main    = 1'b0;
            load_skid    = 1'b0;
            skid_to_main = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_data_q <= up_data_i;
                main_ctrl_q <= up_ctrl_i;
            end else if (skid_to_main) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end
            if (load_skid) begin
                skid_data_q <= up_data_i;
                skid_ctrl_q <= up_ctrl_i;
            end
        end
    end

`ifdef PIPE_REG_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating; deliberately not cleared by flush so stall history survives bubbles.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (dn_valid_o && !dn_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
